game_master: RTL and testbench
==============================

# game_master

Player-1 (master-board) game controller for two-board Bingo. It runs its own 5x5 board, with selection, guess marking and line counting. It also drives the interboard message protocol from the initiating side: it announces the game, hands the selection turn to the slave, alternates guesses with the slave, and declares or accepts a win. It sits between the keypad/BCD entry logic, the interboard link transmitter/receiver and the display, and is the peer of the slave game controller.

## Interface
Parameters:
- WIN_LINES, 3: number of completed lines (5 rows, 5 columns, 2 diagonals) required to win.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cur_number_BCD  in  8  keypad number as two BCD digits, [7:4] tens, [3:0] ones
- enter_pulse  in  1  one-cycle confirm of cur_number_BCD
- start_pulse  in  1  one-cycle start/restart request from the player
- inter_ready  in  1  link finished sending the current message
- interboard_en  in  1  one-cycle strobe: received message valid
- interboard_msg_type  in  3  received type: `STATE_TURN`, `SEL_NUM` or `STATE_WIN` (message_macro.v)
- interboard_number  in  5  received number, 1..25
- my_turn  out  1  the local player is expected to act
- transmit  out  1  a send is in progress
- ctrl_en  out  1  one-cycle request to the link to start a send
- ctrl_msg_type  out  3  type of the message being sent
- ctrl_number  out  5  number of the message being sent
- map  out  125  cell i occupies [5i+4:5i]; 0 means empty; holds the number 1..25
- circle  out  25  bit i set when cell i is marked

## Operation
- cur_number = 10*tens + ones, computed at 7 bits. An entry is valid only if it is in 1..25. Other entries are ignored.
- FSM states:
  - IDLE
  - SEND_START
  - P1_SEL
  - SEND_TURN
  - WAIT_P2_SEL
  - P1_GUESS
  - CHECK_WIN
  - SEND_SEL
  - SEND_WIN
  - WAIT_P2_GUESS
  - UPDATE
  - FIN
  - SEND_RESTART
- FSM transitions:
  - IDLE, start_pulse -> SEND_START (`STATE_TURN`). On inter_ready -> P1_SEL.
  - P1_SEL, valid enter_pulse with a number not already in map: the number is written at position pos, then pos increments. Duplicates are ignored. After the 25th write -> SEND_TURN (`STATE_TURN`). On inter_ready -> WAIT_P2_SEL.
  - WAIT_P2_SEL, rx `STATE_TURN` -> P1_GUESS.
  - P1_GUESS, valid enter_pulse whose cell is not yet circled: the cell is circled and the number is latched -> CHECK_WIN. Already-circled numbers are ignored.
  - CHECK_WIN: lines >= WIN_LINES -> SEND_WIN (`STATE_WIN`). Otherwise -> SEND_SEL (`SEL_NUM`, latched number).
  - SEND_SEL, inter_ready -> WAIT_P2_GUESS.
  - SEND_WIN, inter_ready -> FIN.
  - WAIT_P2_GUESS, rx `SEL_NUM` -> UPDATE, circling the cell that holds interboard_number. If the cell is already circled, nothing changes.
  - WAIT_P2_GUESS, rx `STATE_WIN` -> FIN.
  - UPDATE: lines >= WIN_LINES -> SEND_WIN. Otherwise -> P1_GUESS.
  - FIN, start_pulse -> SEND_RESTART (`STATE_TURN`). On inter_ready -> IDLE.
- Received messages of any type not listed for the current state are ignored.
- map, circle and pos clear on entry to IDLE and on rst.
- Line count is combinational over circle: 12 AND-reductions summed into a 4-bit count.
- Number-to-cell lookup is a combinational search over map.
- my_turn = P1_SEL | P1_GUESS | FIN.
- transmit = 1 in every SEND_* state.

## Timing
- Reset values:
  - FSM state: IDLE
  - map: 0
  - circle: 0
  - pos: 0
  - latched number: 0
  - my_turn: 0
  - transmit: 0
  - ctrl_en: 0
  - ctrl_msg_type: 3'b111
  - ctrl_number: 0
- rst mid-game (any state, including during a send) returns everything to reset values on the next edge. No message is sent.
- ctrl_en is high for exactly the first cycle of each SEND_* state.
- ctrl_msg_type and ctrl_number are registered, valid from that first cycle, and stable until the state exits.
- In states that are not SEND_*, ctrl_msg_type is 3'b111.
- inter_ready is ignored in the cycle ctrl_en is high. In any later SEND cycle it causes exit on the next edge.
- Latencies:
  - Local guess enter_pulse to ctrl_en: 2 cycles (P1_GUESS -> CHECK_WIN -> SEND_*).
  - Received `SEL_NUM` to circle update: 1 cycle.
  - Received `SEL_NUM` to win decision: 2 cycles.
- enter_pulse outside P1_SEL and P1_GUESS has no effect.
- start_pulse outside IDLE and FIN has no effect.
- enter_pulse on the same cycle as a received message is handled per the current state only.
- pos saturates at 24. The 25th write always transitions; pos never wraps.

## Test plan
- Reset then start_pulse: ctrl_en pulses with `STATE_TURN` and transmit stays high. Holding inter_ready at 0 keeps the state in SEND_START. After inter_ready -> P1_SEL and my_turn = 1.
- Enter 25 then 5 then 25 then 0 then 30: map cell0 = 25, cell1 = 5, pos = 2 (the duplicate, zero and 30 are ignored). Enter the remaining 23 numbers: ctrl_en with `STATE_TURN`, then inter_ready -> WAIT_P2_SEL.
- Rx `STATE_TURN`, then guess 7: circle sets 7's cell. 2 cycles later ctrl_en with `SEL_NUM`/7. inter_ready -> WAIT_P2_GUESS with my_turn = 0.
- Rx `SEL_NUM`/13 that completes the 3rd line: UPDATE, then SEND_WIN with `STATE_WIN`, then inter_ready -> FIN.
- Rx `STATE_WIN` in WAIT_P2_GUESS -> FIN. start_pulse -> `STATE_TURN` send, then IDLE with map = 0 and circle = 0.
- Assert rst during SEND_SEL: next cycle state is IDLE, transmit = 0, ctrl_msg_type = 3'b111, and map and circle are cleared.

Source files
------------

// File: rtl/game_master.sv
// game_master: player-1 Bingo controller. It owns the local 5x5 board
// (selection, marking, line counting) and runs the initiating side of the
// interboard protocol: start announcement, selection hand-off, alternating
// guesses with the slave board, and win declaration / acceptance.
module game_master #(
    parameter int WIN_LINES = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   cur_number_BCD,
    input  logic         enter_pulse,
    input  logic         start_pulse,
    input  logic         inter_ready,
    input  logic         interboard_en,
    input  logic [2:0]   interboard_msg_type,
    input  logic [4:0]   interboard_number,
    output logic         my_turn,
    output logic         transmit,
    output logic         ctrl_en,
    output logic [2:0]   ctrl_msg_type,
    output logic [4:0]   ctrl_number,
    output logic [124:0] map,
    output logic [24:0]  circle
);

    // Interboard message encodings shared with the slave controller.
    localparam logic [2:0] STATE_TURN = 3'd1;
    localparam logic [2:0] SEL_NUM    = 3'd2;
    localparam logic [2:0] STATE_WIN  = 3'd3;
    localparam logic [2:0] MSG_NONE   = 3'b111;

    localparam logic [3:0] WIN_CNT  = 4'(WIN_LINES);
    localparam logic [4:0] LAST_POS = 5'd24;

    typedef enum logic [3:0] {
        IDLE,
        SEND_START,
        P1_SEL,
        SEND_TURN,
        WAIT_P2_SEL,
        P1_GUESS,
        CHECK_WIN,
        SEND_SEL,
        SEND_WIN,
        WAIT_P2_GUESS,
        UPDATE,
        FIN,
        SEND_RESTART
    } state_t;

    state_t      state_reg, state_next;

    logic [4:0]  map_reg [25];
    logic [24:0] circle_reg;
    logic [4:0]  pos_reg;
    logic [4:0]  latched_reg;
    logic        ctrl_en_reg;
    logic [2:0]  ctrl_msg_type_reg;
    logic [4:0]  ctrl_number_reg;

    // Keypad value and board searches.
    logic [6:0]  cur_number;
    logic        cur_valid;
    logic [24:0] cur_hit;
    logic [24:0] rx_hit;
    logic        cur_dup;
    logic        guess_ok;

    // Line detection.
    logic [11:0] line_done;
    logic [3:0]  line_count;
    logic        win;

    // FSM side effects.
    logic        sel_write;
    logic        guess_take;
    logic        rx_take;
    logic        clear_board;
    logic        send_exit;

    function automatic logic is_send(state_t s);
        return (s == SEND_START) || (s == SEND_TURN) || (s == SEND_SEL) ||
               (s == SEND_WIN)   || (s == SEND_RESTART);
    endfunction

    assign cur_number = {3'b000, cur_number_BCD[7:4]} * 7'd10 + {3'b000, cur_number_BCD[3:0]};
    assign cur_valid  = (cur_number >= 7'd1) && (cur_number <= 7'd25);

    // Per-cell match vectors; the board never holds a number twice, so each
    // vector is at most one-hot and can be OR-ed straight into circle.
    genvar gi;
    generate
        for (gi = 0; gi < 25; gi++) begin : g_cells
            assign cur_hit[gi] = cur_valid && (map_reg[gi] == cur_number[4:0]);
            assign rx_hit[gi]  = (interboard_number != 5'd0) && (map_reg[gi] == interboard_number);
            assign map[5*gi +: 5] = map_reg[gi];
        end
    endgenerate

    assign cur_dup  = |cur_hit;
    assign guess_ok = |(cur_hit & ~circle_reg);

    // Rows 0..4, columns 5..9, main diagonal 10, anti-diagonal 11.
    generate
        for (gi = 0; gi < 5; gi++) begin : g_lines
            assign line_done[gi]     = &circle_reg[5*gi +: 5];
            assign line_done[5 + gi] = circle_reg[gi] & circle_reg[gi + 5] & circle_reg[gi + 10] &
                                       circle_reg[gi + 15] & circle_reg[gi + 20];
        end
    endgenerate
    assign line_done[10] = circle_reg[0] & circle_reg[6] & circle_reg[12] & circle_reg[18] & circle_reg[24];
    assign line_done[11] = circle_reg[4] & circle_reg[8] & circle_reg[12] & circle_reg[16] & circle_reg[20];

    // Sum of completed lines.
    always_comb begin
        line_count = 4'd0;
        for (int i = 0; i < 12; i++) begin
            line_count = line_count + {3'b000, line_done[i]};
        end
    end

    assign win = (line_count >= WIN_CNT);

    // The link's ready is only honoured once the start request has gone out.
    assign send_exit = inter_ready && !ctrl_en_reg;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and board update strobes.
    always_comb begin
        state_next = state_reg;
        sel_write  = 1'b0;
        guess_take = 1'b0;
        rx_take    = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (start_pulse) state_next = SEND_START;
            end
            SEND_START: begin
                if (send_exit) state_next = P1_SEL;
            end
            P1_SEL: begin
                if (enter_pulse && cur_valid && !cur_dup) begin
                    sel_write = 1'b1;
                    if (pos_reg == LAST_POS) state_next = SEND_TURN;
                end
            end
            SEND_TURN: begin
                if (send_exit) state_next = WAIT_P2_SEL;
            end
            WAIT_P2_SEL: begin
                if (interboard_en && interboard_msg_type == STATE_TURN) state_next = P1_GUESS;
            end
            P1_GUESS: begin
                if (enter_pulse && guess_ok) begin
                    guess_take = 1'b1;
                    state_next = CHECK_WIN;
                end
            end
            CHECK_WIN: begin
                state_next = win ? SEND_WIN : SEND_SEL;
            end
            SEND_SEL: begin
                if (send_exit) state_next = WAIT_P2_GUESS;
            end
            SEND_WIN: begin
                if (send_exit) state_next = FIN;
            end
            WAIT_P2_GUESS: begin
                if (interboard_en && interboard_msg_type == SEL_NUM) begin
                    rx_take    = 1'b1;
                    state_next = UPDATE;
                end else if (interboard_en && interboard_msg_type == STATE_WIN) begin
                    state_next = FIN;
                end
            end
            UPDATE: begin
                state_next = win ? SEND_WIN : P1_GUESS;
            end
            FIN: begin
                if (start_pulse) state_next = SEND_RESTART;
            end
            SEND_RESTART: begin
                if (send_exit) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign clear_board = (state_next == IDLE) && (state_reg != IDLE);

    // Board contents, marks and selection pointer; cleared whenever IDLE is re-entered.
    always_ff @(posedge clk) begin
        if (rst || clear_board) begin
            for (int i = 0; i < 25; i++) begin
                map_reg[i] <= 5'd0;
            end
            circle_reg <= 25'd0;
            pos_reg    <= 5'd0;
        end else begin
            if (sel_write) begin
                map_reg[pos_reg] <= cur_number[4:0];
                if (pos_reg != LAST_POS) pos_reg <= pos_reg + 5'd1;
            end
            if (guess_take) circle_reg <= circle_reg | cur_hit;
            if (rx_take)    circle_reg <= circle_reg | rx_hit;
        end
    end

    // Local guess held for the SEL_NUM message.
    always_ff @(posedge clk) begin
        if (rst) begin
            latched_reg <= 5'd0;
        end else if (guess_take) begin
            latched_reg <= cur_number[4:0];
        end
    end

    // Outgoing message registers: strobe on entry to a send state, payload held until exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_en_reg       <= 1'b0;
            ctrl_msg_type_reg <= MSG_NONE;
            ctrl_number_reg   <= 5'd0;
        end else begin
            ctrl_en_reg <= is_send(state_next) && (state_next != state_reg);
            case (state_next)
                SEND_START, SEND_TURN, SEND_RESTART: begin
                    ctrl_msg_type_reg <= STATE_TURN;
                    ctrl_number_reg   <= 5'd0;
                end
                SEND_SEL: begin
                    ctrl_msg_type_reg <= SEL_NUM;
                    ctrl_number_reg   <= latched_reg;
                end
                SEND_WIN: begin
                    ctrl_msg_type_reg <= STATE_WIN;
                    ctrl_number_reg   <= 5'd0;
                end
                default: begin
                    ctrl_msg_type_reg <= MSG_NONE;
                    ctrl_number_reg   <= 5'd0;
                end
            endcase
        end
    end

    assign ctrl_en       = ctrl_en_reg;
    assign ctrl_msg_type = ctrl_msg_type_reg;
    assign ctrl_number   = ctrl_number_reg;
    assign circle        = circle_reg;
    assign my_turn       = (state_reg == P1_SEL) || (state_reg == P1_GUESS) || (state_reg == FIN);
    assign transmit      = is_send(state_reg);

endmodule

// File: tb/tb_game_master.sv
// tb_game_master: randomized games against a board-level reference model.
// Expected outgoing messages are queued by the stimulus and consumed by a
// monitor whenever the DUT strobes ctrl_en.
module tb_game_master;

    localparam logic [2:0] STATE_TURN = 3'd1;
    localparam logic [2:0] SEL_NUM    = 3'd2;
    localparam logic [2:0] STATE_WIN  = 3'd3;
    localparam int         WIN_LINES  = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   cur_number_BCD;
    logic         enter_pulse;
    logic         start_pulse;
    logic         inter_ready;
    logic         interboard_en;
    logic [2:0]   interboard_msg_type;
    logic [4:0]   interboard_number;
    logic         my_turn;
    logic         transmit;
    logic         ctrl_en;
    logic [2:0]   ctrl_msg_type;
    logic [4:0]   ctrl_number;
    logic [124:0] map;
    logic [24:0]  circle;

    game_master #(.WIN_LINES(WIN_LINES)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .cur_number_BCD      (cur_number_BCD),
        .enter_pulse         (enter_pulse),
        .start_pulse         (start_pulse),
        .inter_ready         (inter_ready),
        .interboard_en       (interboard_en),
        .interboard_msg_type (interboard_msg_type),
        .interboard_number   (interboard_number),
        .my_turn             (my_turn),
        .transmit            (transmit),
        .ctrl_en             (ctrl_en),
        .ctrl_msg_type       (ctrl_msg_type),
        .ctrl_number         (ctrl_number),
        .map                 (map),
        .circle              (circle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] t;
        logic [4:0] n;
    } msg_t;

    msg_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: board contents in selection order and mark flags.
    int   board [25];
    bit   circ  [25];
    int   mpos;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [124:0] got, input logic [124:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end else begin
            $display("ok   %s = %0h", name, got);
        end
    endtask

    task automatic expect_msg(input logic [2:0] t, input logic [4:0] n);
        msg_t m;
        m.t = t;
        m.n = n;
        exp_q.push_back(m);
    endtask

    function automatic logic [124:0] model_map();
        logic [124:0] v = '0;
        for (int i = 0; i < 25; i++) v[5*i +: 5] = 5'(board[i]);
        return v;
    endfunction

    function automatic logic [124:0] model_circle();
        logic [124:0] v = '0;
        for (int i = 0; i < 25; i++) v[i] = circ[i];
        return v;
    endfunction

    function automatic int model_lines();
        int  cnt = 0;
        bit  all;
        for (int r = 0; r < 5; r++) begin
            all = 1;
            for (int c = 0; c < 5; c++) if (!circ[5*r + c]) all = 0;
            if (all) cnt++;
        end
        for (int c = 0; c < 5; c++) begin
            all = 1;
            for (int r = 0; r < 5; r++) if (!circ[5*r + c]) all = 0;
            if (all) cnt++;
        end
        all = 1;
        for (int i = 0; i < 5; i++) if (!circ[6*i]) all = 0;
        if (all) cnt++;
        all = 1;
        for (int i = 0; i < 5; i++) if (!circ[4 + 4*i]) all = 0;
        if (all) cnt++;
        return cnt;
    endfunction

    function automatic int cell_of(input int n);
        for (int i = 0; i < 25; i++) if (board[i] == n) return i;
        return -1;
    endfunction

    function automatic bit placed(input int n);
        for (int i = 0; i < mpos; i++) if (board[i] == n) return 1;
        return 0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 25; i++) begin
            board[i] = 0;
            circ[i]  = 0;
        end
        mpos = 0;
    endtask

    task automatic press(input int t, input int o);
        cur_number_BCD = {4'(t), 4'(o)};
        enter_pulse    = 1'b1;
        tick();
        enter_pulse    = 1'b0;
    endtask

    task automatic press_num(input int n);
        press(n / 10, n % 10);
    endtask

    // Selection-phase entry: model decides acceptance, DUT gets the keystroke.
    task automatic sel_enter(input int t, input int o);
        int v = 10*t + o;
        if (v >= 1 && v <= 25 && !placed(v)) begin
            board[mpos] = v;
            mpos++;
            if (mpos == 25) expect_msg(STATE_TURN, 5'd0);
        end
        press(t, o);
    endtask

    task automatic pulse_start();
        start_pulse = 1'b1;
        tick();
        start_pulse = 1'b0;
    endtask

    task automatic rx(input logic [2:0] t, input int n);
        interboard_en       = 1'b1;
        interboard_msg_type = t;
        interboard_number   = 5'(n);
        tick();
        interboard_en       = 1'b0;
    endtask

    // Complete one outgoing send: ready is raised during the ctrl_en cycle
    // (must be ignored), optionally dropped for w cycles, then accepted.
    task automatic do_send(input int w);
        int seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (ctrl_en === 1'b1) begin
                seen = 1;
                break;
            end
            tick();
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got=no_ctrl_en exp=ctrl_en");
            return;
        end
        inter_ready = 1'b1;
        tick();
        check("transmit_after_en", transmit, 1'b1);
        if (w > 0) begin
            inter_ready = 1'b0;
            repeat (w) tick();
            check("transmit_held", transmit, 1'b1);
            inter_ready = 1'b1;
        end
        tick();
        inter_ready = 1'b0;
        check("transmit_done", transmit, 1'b0);
    endtask

    // Fill the rest of the board, mixing in junk and duplicate keystrokes.
    task automatic fill_board();
        int guard = 0;
        while (mpos < 25 && guard < 400) begin
            guard++;
            if ($urandom_range(3) == 0) begin
                sel_enter($urandom_range(9), $urandom_range(9));
            end else begin
                int n;
                do n = $urandom_range(25, 1); while (placed(n));
                sel_enter(n / 10, n % 10);
            end
        end
        do_send($urandom_range(2));
        check("map_full", map, model_map());
        check("my_turn_wait_sel", my_turn, 1'b0);
    endtask

    task automatic start_game(input int w);
        model_clear();
        expect_msg(STATE_TURN, 5'd0);
        pulse_start();
        do_send(w);
        check("my_turn_p1_sel", my_turn, 1'b1);
    endtask

    // Local guess; returns 1 when it wins the game.
    task automatic p1_guess(input int n, output bit won);
        circ[cell_of(n)] = 1;
        won = (model_lines() >= WIN_LINES);
        if (won) expect_msg(STATE_WIN, 5'd0);
        else     expect_msg(SEL_NUM, 5'(n));
        press_num(n);
        check("circle_p1", circle, model_circle());
        do_send($urandom_range(2));
    endtask

    function automatic int pick_uncircled();
        int cand[$];
        for (int i = 0; i < 25; i++) if (!circ[i]) cand.push_back(board[i]);
        return cand[$urandom_range(cand.size() - 1)];
    endfunction

    function automatic int pick_circled();
        int cand[$];
        for (int i = 0; i < 25; i++) if (circ[i]) cand.push_back(board[i]);
        if (cand.size() == 0) return 0;
        return cand[$urandom_range(cand.size() - 1)];
    endfunction

    // Monitor: consumes queued expectations on every ctrl_en strobe.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (ctrl_en === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_send got=%0d/%0d exp=none", ctrl_msg_type, ctrl_number);
                end else begin
                    msg_t e;
                    e = exp_q.pop_front();
                    if (ctrl_msg_type !== e.t || ctrl_number !== e.n) begin
                        errors++;
                        $display("FAIL send_msg got=%0d/%0d exp=%0d/%0d", ctrl_msg_type, ctrl_number, e.t, e.n);
                    end else begin
                        $display("ok   send_msg %0d/%0d", ctrl_msg_type, ctrl_number);
                    end
                end
            end
            if (transmit === 1'b0) begin
                checks++;
                if (ctrl_msg_type !== 3'b111) begin
                    errors++;
                    $display("FAIL idle_msg_type got=%0d exp=7", ctrl_msg_type);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit won;
        int g, n, m;

        rst = 1'b1;
        cur_number_BCD = 8'd0;
        enter_pulse = 1'b0;
        start_pulse = 1'b0;
        inter_ready = 1'b0;
        interboard_en = 1'b0;
        interboard_msg_type = 3'd0;
        interboard_number = 5'd0;
        model_clear();
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("rst_map", map, 125'd0);
        check("rst_circle", circle, 125'd0);
        check("rst_my_turn", my_turn, 1'b0);
        check("rst_transmit", transmit, 1'b0);
        check("rst_ctrl_en", ctrl_en, 1'b0);
        check("rst_msg_type", ctrl_msg_type, 3'b111);
        check("rst_number", ctrl_number, 5'd0);

        // ---------------- Game 1: full random game ----------------
        start_game(3);
        sel_enter(2, 5);
        sel_enter(0, 5);
        sel_enter(2, 5);
        sel_enter(0, 0);
        sel_enter(3, 0);
        check("map_first_two", map, model_map());
        fill_board();

        // Ignored inputs while waiting for the slave's selection.
        press_num(board[0]);
        rx(SEL_NUM, board[0]);
        check("wait_sel_ignored", circle, 125'd0);
        check("wait_sel_my_turn", my_turn, 1'b0);
        rx(STATE_TURN, 0);
        check("my_turn_guess", my_turn, 1'b1);

        won = 0;
        g = 0;
        while (!won && g < 40) begin
            g++;
            n = pick_circled();
            if (n != 0 && $urandom_range(2) == 0) begin
                press_num(n);
                check("dup_guess_circle", circle, model_circle());
                check("dup_guess_my_turn", my_turn, 1'b1);
            end
            n = (g == 1) ? 7 : pick_uncircled();
            p1_guess(n, won);
            if (won) break;
            check("my_turn_wait_guess", my_turn, 1'b0);
            m = $urandom_range(25, 1);
            circ[cell_of(m)] = 1;
            won = (model_lines() >= WIN_LINES);
            if (won) expect_msg(STATE_WIN, 5'd0);
            rx(SEL_NUM, m);
            check("circle_p2", circle, model_circle());
            if (won) begin
                do_send($urandom_range(2));
            end else begin
                tick();
                check("my_turn_back", my_turn, 1'b1);
            end
        end
        check("game1_fin", my_turn, 1'b1);
        expect_msg(STATE_TURN, 5'd0);
        pulse_start();
        do_send(1);
        model_clear();
        check("restart_map", map, 125'd0);
        check("restart_circle", circle, 125'd0);
        check("restart_my_turn", my_turn, 1'b0);

        // ---------------- Game 2: slave declares win ----------------
        start_game(0);
        fill_board();
        rx(STATE_TURN, 0);
        p1_guess(pick_uncircled(), won);
        rx(STATE_TURN, 0);
        check("wrong_type_ignored", my_turn, 1'b0);
        rx(STATE_WIN, 0);
        check("rx_win_fin", my_turn, 1'b1);
        check("rx_win_transmit", transmit, 1'b0);
        expect_msg(STATE_TURN, 5'd0);
        pulse_start();
        do_send(0);
        model_clear();
        check("restart2_map", map, 125'd0);

        // ---------------- Game 3: reset during SEND_SEL ----------------
        start_game(0);
        fill_board();
        rx(STATE_TURN, 0);
        n = pick_uncircled();
        circ[cell_of(n)] = 1;
        expect_msg(SEL_NUM, 5'(n));
        press_num(n);
        for (int i = 0; i < 10 && ctrl_en !== 1'b1; i++) tick();
        tick();
        check("sel_transmit", transmit, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        check("midrst_transmit", transmit, 1'b0);
        check("midrst_msg_type", ctrl_msg_type, 3'b111);
        check("midrst_map", map, 125'd0);
        check("midrst_circle", circle, 125'd0);
        check("midrst_my_turn", my_turn, 1'b0);
        check("midrst_ctrl_en", ctrl_en, 1'b0);
        start_game(0);

        repeat (3) tick();
        check("queue_empty", 125'(exp_q.size()), 125'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
